mem_out_ctrl: RTL and testbench

Sequencer that drives the active-low CEN/WEN banked output memory, which has one-cycle read latency.
- Write mode: accepts a valid/ready stream of result words from the systolic array and writes them to consecutive addresses starting at 0.
- Read mode: streams a given number of words back out over valid/ready with full backpressure, hiding the read latency behind a 2-entry skid FIFO.
- Sits between the array drain logic and the output memory instance.

---
 rtl/mem_out_pkg.sv | 20 ++
 rtl/mem_out_skid_fifo.sv | 41 ++++
 rtl/mem_out_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_out_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_out_pkg.sv
// Shared types and sizing for the output-memory sequencer.
// Bank geometry, state encoding and address-width helper.
package mem_out_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam int WORD_LEN_DEF = 32;
   localparam int BANK_WORDS   = 256;
   localparam int BANK_BITS    = 8;

   function automatic int addr_width(input int addr_len);
      return addr_len + BANK_BITS;
   endfunction

endpackage

// File: rtl/mem_out_skid_fifo.sv
// mem_out_skid_fifo: 2-entry FIFO catching read data; push visible at head next cycle.
// No internal backpressure: the caller keeps occupancy <= 2 (push+pop allowed at count 1 or 2).
module mem_out_skid_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] slot [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // The write slot is never the head while count > 0, so head holds during a stall.
   assign head = slot[rd_ptr];

endmodule

// File: rtl/mem_out_ctrl.sv
// mem_out_ctrl: write/read sequencer for the CEN/WEN output memory (stall counter: MEM_OUT_CTRL_STALL_CNT_EN).
// Writes go combinationally to memory; reads reach out_valid 2 cycles after issue, one word/cycle, full backpressure.
module mem_out_ctrl
   import mem_out_pkg::*;
#(
   parameter int SUB_MEMS = 4,
   parameter int ADDR_LEN = 2,
   parameter int WORD_LEN = WORD_LEN_DEF,
   localparam int AW      = addr_width(ADDR_LEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_wr,
   input  logic                start_rd,
   input  logic [AW:0]         num_words,
   input  logic                in_valid,
   input  logic [WORD_LEN-1:0] in_data,
   output logic                in_ready,
   output logic                out_valid,
   output logic [WORD_LEN-1:0] out_data,
   input  logic                out_ready,
   output logic                busy,
   output logic                done,
   output logic                mem_CEN,
   output logic                mem_WEN,
   output logic [AW-1:0]       mem_A,
   output logic [WORD_LEN-1:0] mem_D,
   input  logic [WORD_LEN-1:0] mem_Q
`ifdef MEM_OUT_CTRL_STALL_CNT_EN
   ,
   output logic [31:0]         stall_cnt
`endif
);

   localparam logic [AW:0] MAX_LEN = (AW+1)'(SUB_MEMS * BANK_WORDS);
   localparam logic [AW:0] ONE     = (AW+1)'(1);

   state_t        state, state_nxt;
   logic [AW:0]   len_q, len_in;
   logic [AW:0]   wr_cnt, rd_iss, rd_pop;
   logic          inflight;
   logic [1:0]    fifo_cnt;
   logic [2:0]    occ;
   logic          start_acc, wr_acc, rd_issue, pop;

   // Over-range lengths are clamped so the address never wraps past the top bank.
   assign len_in    = (num_words > MAX_LEN) ? MAX_LEN : num_words;
   assign start_acc = (state == IDLE) && (start_wr || start_rd);
   assign out_valid = (fifo_cnt != 2'd0);
   assign pop       = out_valid && out_ready;
   assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight};
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      mem_CEN   = 1'b1;
      mem_WEN   = 1'b1;
      mem_A     = '0;
      mem_D     = '0;
      wr_acc    = 1'b0;
      rd_issue  = 1'b0;
      case (state)
         IDLE: begin
            if (start_wr || start_rd) begin
               if (len_in == '0)  state_nxt = FIN;
               else if (start_wr) state_nxt = WR;
               else               state_nxt = RD;
            end
         end
         WR: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_acc  = 1'b1;
               mem_CEN = 1'b0;
               mem_WEN = 1'b0;
               mem_A   = wr_cnt[AW-1:0];
               mem_D   = in_data;
               if (wr_cnt + ONE == len_q) state_nxt = FIN;
            end
         end
         RD: begin
            // Issue only if the word will have a FIFO slot when it returns.
            if ((rd_iss < len_q) && ((occ < 3'd2) || ((occ == 3'd2) && pop))) begin
               rd_issue = 1'b1;
               mem_CEN  = 1'b0;
               mem_A    = rd_iss[AW-1:0];
            end
            if (pop && (rd_pop + ONE == len_q)) state_nxt = FIN;
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         wr_cnt   <= '0;
         rd_iss   <= '0;
         rd_pop   <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= rd_issue;
         if (start_acc) begin
            len_q  <= len_in;
            wr_cnt <= '0;
            rd_iss <= '0;
            rd_pop <= '0;
         end
         if (wr_acc)   wr_cnt <= wr_cnt + ONE;
         if (rd_issue) rd_iss <= rd_iss + ONE;
         if (pop)      rd_pop <= rd_pop + ONE;
      end
   end

   mem_out_skid_fifo #(
      .WIDTH (WORD_LEN)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (mem_Q),
      .pop       (pop),
      .count     (fifo_cnt),
      .head      (out_data)
   );

`ifdef MEM_OUT_CTRL_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (start_acc) begin
         stall_cnt <= '0;
      end else if ((((state == WR) && !in_valid) || (out_valid && !out_ready)) &&
                   (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_out_ctrl.sv
// Bench for mem_out_ctrl: behavioural 1-cycle-latency memory plus write/read scoreboards.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_out_ctrl;

   localparam int AW = 10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_wr, start_rd;
   logic [AW:0]   num_words;
   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;
   logic          out_valid;
   logic [31:0]   out_data;
   logic          out_ready;
   logic          busy, done;
   logic          mem_CEN, mem_WEN;
   logic [AW-1:0] mem_A;
   logic [31:0]   mem_D;
   logic [31:0]   mem_Q;
`ifdef MEM_OUT_CTRL_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   logic [31:0] mem_arr [0:1023];
   logic [31:0] ref_mem [0:1023];
   wr_t         exp_wr [$];
   logic [31:0] exp_rd [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   mem_out_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start_wr  (start_wr),
      .start_rd  (start_rd),
      .num_words (num_words),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .mem_CEN   (mem_CEN),
      .mem_WEN   (mem_WEN),
      .mem_A     (mem_A),
      .mem_D     (mem_D),
`ifdef MEM_OUT_CTRL_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .mem_Q     (mem_Q)
   );

   // Memory model: write on CEN&WEN low, registered read on CEN low / WEN high.
   always @(posedge clk) begin
      if (mem_CEN === 1'b0) begin
         if (mem_WEN === 1'b0) mem_arr[mem_A] <= mem_D;
         else                  mem_Q <= mem_arr[mem_A];
      end
   end

   function automatic logic [31:0] data_of(input int tag, input int i);
      if (tag == 0) return 32'hA0 + 32'(i);
      return (32'(tag) << 28) ^ (32'(i) * 32'h0001_0003) ^ 32'h5A5A;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_done_busy: got %b%b expected 00", done, busy); end
      n_checks++; if (mem_CEN !== 1'b1 || mem_WEN !== 1'b1) begin n_fail++; $display("FAIL rst_cen_wen: got %b%b expected 11", mem_CEN, mem_WEN); end
      n_checks++; if (mem_A !== '0 || mem_D !== '0) begin n_fail++; $display("FAIL rst_addr_data: got %0h/%0h expected 0/0", mem_A, mem_D); end
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic write_seq(input int n, input int tag, input bit both, input bit gaps);
      int  acc, pushed, dones;
      wr_t e;
      acc = 0; pushed = 0; dones = 0;
      num_words = (AW+1)'(n);
      start_wr  = 1'b1;
      start_rd  = both;
      tick();
      start_wr = 1'b0;
      start_rd = 1'b0;
      for (int cyc = 0; cyc < 3*n + 20; cyc++) begin
         in_valid = (acc < n) && (!gaps || ($urandom_range(0, 3) != 0));
         start_rd = gaps && (cyc == 2);
         if (acc < n && pushed == acc) begin
            in_data = data_of(tag, acc);
            exp_wr.push_back({AW'(acc), in_data});
            pushed++;
         end
         @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            n_checks++; if (acc != n) begin n_fail++; $display("FAIL wr_count: got %0d expected %0d", acc, n); end
            break;
         end
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL wr_in_ready: got %b expected 1", in_ready); end
         if (mem_CEN === 1'b0) begin
            n_checks++;
            if (exp_wr.size() == 0) begin
               n_fail++; $display("FAIL wr_extra: got write to %0d expected none", mem_A);
            end else begin
               e = exp_wr.pop_front();
               if (mem_WEN !== 1'b0 || mem_A !== e.addr || mem_D !== e.data) begin
                  n_fail++;
                  $display("FAIL wr_port: got wen=%b a=%0d d=%0h expected wen=0 a=%0d d=%0h", mem_WEN, mem_A, mem_D, e.addr, e.data);
               end
               ref_mem[e.addr] = e.data;
            end
            acc++;
         end else if (in_valid) begin
            n_checks++; n_fail++;
            $display("FAIL wr_stall: got CEN=%b with in_valid expected 0", mem_CEN);
         end
         tick();
      end
      in_valid = 1'b0;
      start_rd = 1'b0;
      n_checks++; if (dones != 1) begin n_fail++; $display("FAIL wr_done: got %0d pulses expected 1", dones); end
      n_checks++; if (exp_wr.size() != 0) begin n_fail++; $display("FAIL wr_left: got %0d pending expected 0", exp_wr.size()); end
      exp_wr.delete();
      tick();
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got done=%b busy=%b expected 0 0", done, busy); end
      tick();
   endtask

   task automatic read_seq(input int n, input int mode, input int abort_after);
      int          issued, popped, dones, first_iss, first_vld, first_pop, last_pop;
      bit          held;
      logic [31:0] held_dat, e;
      issued = 0; popped = 0; dones = 0;
      first_iss = -1; first_vld = -1; first_pop = -1; last_pop = -1;
      held = 1'b0; held_dat = '0;
      for (int k = 0; k < n; k++) exp_rd.push_back(ref_mem[k]);
      num_words = (AW+1)'(n);
      start_rd  = 1'b1;
      out_ready = (mode == 0);
      tick();
      start_rd = 1'b0;
      for (int cyc = 0; cyc < 4*n + 20; cyc++) begin
         out_ready = (mode == 0) || (cyc % 3 == 0);
         @(negedge clk);
         if (done === 1'b1) begin
            dones++;
            n_checks++;
            if (popped != n || cyc != last_pop + 1) begin
               n_fail++; $display("FAIL rd_done_timing: got popped=%0d at cyc %0d expected %0d at cyc %0d", popped, cyc, n, last_pop + 1);
            end
            break;
         end
         if (mem_CEN === 1'b0) begin
            if (issued == 0) first_iss = cyc;
            n_checks++;
            if (mem_WEN !== 1'b1 || mem_A !== AW'(issued)) begin
               n_fail++; $display("FAIL rd_issue: got wen=%b a=%0d expected wen=1 a=%0d", mem_WEN, mem_A, issued);
            end
            issued++;
         end
         if (out_valid === 1'b1 && first_vld < 0) first_vld = cyc;
         if (held) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held_dat) begin
               n_fail++; $display("FAIL rd_hold: got v=%b d=%0h expected v=1 d=%0h", out_valid, out_data, held_dat);
            end
         end
         if (out_valid === 1'b1 && out_ready) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
               n_fail++; $display("FAIL rd_extra: got %0h expected no word", out_data);
            end else begin
               e = exp_rd.pop_front();
               if (out_data !== e) begin n_fail++; $display("FAIL rd_data: got %0h expected %0h", out_data, e); end
            end
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            popped++;
         end
         n_checks++; if (issued - popped > 2) begin n_fail++; $display("FAIL rd_buffered: got %0d expected <=2", issued - popped); end
         held     = (out_valid === 1'b1) && !out_ready;
         held_dat = out_data;
         if (abort_after > 0 && popped == abort_after) begin
            tick();
            return;
         end
         tick();
      end
      n_checks++; if (dones != 1) begin n_fail++; $display("FAIL rd_done: got %0d pulses expected 1", dones); end
      n_checks++; if (issued != n) begin n_fail++; $display("FAIL rd_issued: got %0d expected %0d", issued, n); end
      n_checks++; if (first_vld - first_iss != 2) begin n_fail++; $display("FAIL rd_latency: got %0d expected 2", first_vld - first_iss); end
      if (mode == 0) begin
         n_checks++; if (last_pop - first_pop != n - 1) begin n_fail++; $display("FAIL rd_rate: got span %0d expected %0d", last_pop - first_pop, n - 1); end
      end
      n_checks++; if (exp_rd.size() != 0) begin n_fail++; $display("FAIL rd_left: got %0d pending expected 0", exp_rd.size()); end
      exp_rd.delete();
      tick();
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rd_idle: got done=%b busy=%b expected 0 0", done, busy); end
      tick();
   endtask

   task automatic test_zero_len();
      num_words = '0;
      start_rd  = 1'b1;
      @(negedge clk);
      n_checks++; if (mem_CEN !== 1'b1) begin n_fail++; $display("FAIL zero_cen0: got %b expected 1", mem_CEN); end
      tick();
      start_rd = 1'b0;
      @(negedge clk);
      n_checks++; if (done !== 1'b1 || mem_CEN !== 1'b1) begin n_fail++; $display("FAIL zero_fin: got done=%b cen=%b expected 1 1", done, mem_CEN); end
      tick();
      @(negedge clk);
      n_checks++; if (done !== 1'b0 || busy !== 1'b0 || mem_CEN !== 1'b1) begin n_fail++; $display("FAIL zero_idle: got done=%b busy=%b cen=%b expected 0 0 1", done, busy, mem_CEN); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      read_seq(8, 0, 3);
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || mem_CEN !== 1'b1) begin n_fail++; $display("FAIL mid_rst_out: got v=%b cen=%b expected 0 1", out_valid, mem_CEN); end
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_state: got busy=%b done=%b expected 0 0", busy, done); end
      exp_rd.delete();
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b expected 0", done); end
      tick();
      read_seq(4, 0, 0);
   endtask

   initial begin
      rst = 1'b1; start_wr = 1'b0; start_rd = 1'b0; num_words = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      write_seq(4, 0, 1'b0, 1'b0);
      read_seq(4, 0, 0);
      write_seq(8, 1, 1'b0, 1'b1);
      read_seq(8, 1, 0);
      write_seq(1024, 2, 1'b0, 1'b0);
      read_seq(1024, 0, 0);
      test_zero_len();
      write_seq(2, 3, 1'b1, 1'b0);
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before 2000000");
      $fatal(1);
   end

endmodule
